// File: rtl/sprite_motion_controller.sv
// Moves a square sprite once per frame from synchronized button inputs and
// flags which active pixels fall inside it, for the VGA colour mux.
module sprite_motion_controller #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SIZE        = 10,
    parameter int STEP        = 1,
    parameter int STEP_FAST   = 4,
    parameter int RAMP_FRAMES = 30,
    parameter int INIT_X      = 315,
    parameter int INIT_Y      = 235
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       vs,
    input  logic       blank_n,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [9:0] pix_col,
    output logic [9:0] pix_row,
    output logic       sprite_hit,
    output logic       frame_tick
);

    localparam int HOLD_W = $clog2(RAMP_FRAMES + 1);
    localparam logic signed [10:0] X_MAX = 11'(H_ACTIVE - SIZE);
    localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - SIZE);

    typedef enum logic [1:0] {IDLE, CAPTURE, MOVE} state_t;

    // Button vectors are ordered {up, down, left, right}.
    state_t              state_q, state_d;
    logic [3:0]          btn_s1_q, btn_s1_d;
    logic [3:0]          btn_s2_q, btn_s2_d;
    logic [3:0]          btn_lat_q, btn_lat_d;
    logic [9:0]          step_q, step_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                vs_dly_q, vs_dly_d;
    logic                frame_tick_q, frame_tick_d;
    logic [9:0]          pix_col_q, pix_col_d;
    logic [9:0]          pix_row_q, pix_row_d;
    logic                hit_q, hit_d;
    logic [9:0]          pos_x_q, pos_x_d;
    logic [9:0]          pos_y_q, pos_y_d;

    logic signed [10:0]  x_next, y_next, step_s;
    logic [10:0]         col_ext, row_ext, px_ext, py_ext;
    logic                in_x, in_y;

    always_comb begin
        state_d      = state_q;
        btn_lat_d    = btn_lat_q;
        step_d       = step_q;
        hold_d       = hold_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        pix_col_d    = pix_col_q;
        pix_row_d    = pix_row_q;
        btn_s1_d     = {up, down, left, right};
        btn_s2_d     = btn_s1_q;
        vs_dly_d     = vs;
        frame_tick_d = vs_dly_q & ~vs;

        if (frame_tick_q) begin
            pix_col_d = '0;
            pix_row_d = '0;
        end else if (blank_n) begin
            if (pix_col_q == 10'(H_ACTIVE - 1)) begin
                pix_col_d = '0;
                pix_row_d = (pix_row_q == 10'(V_ACTIVE - 1)) ? '0 : pix_row_q + 10'd1;
            end else begin
                pix_col_d = pix_col_q + 10'd1;
            end
        end

        // Widened to 11 bits so pos+SIZE never wraps near the right/bottom edge.
        col_ext = {1'b0, pix_col_q};
        row_ext = {1'b0, pix_row_q};
        px_ext  = {1'b0, pos_x_q};
        py_ext  = {1'b0, pos_y_q};
        in_x    = (col_ext >= px_ext) && (col_ext < px_ext + 11'(SIZE));
        in_y    = (row_ext >= py_ext) && (row_ext < py_ext + 11'(SIZE));
        hit_d   = blank_n & in_x & in_y;

        step_s = $signed({1'b0, step_q});
        x_next = $signed({1'b0, pos_x_q});
        y_next = $signed({1'b0, pos_y_q});

        case (state_q)
            IDLE: begin
                if (frame_tick_q) state_d = CAPTURE;
            end
            CAPTURE: begin
                btn_lat_d = btn_s2_q;
                step_d    = (hold_q < HOLD_W'(RAMP_FRAMES)) ? 10'(STEP) : 10'(STEP_FAST);
                if (|btn_s2_q)
                    hold_d = (hold_q == HOLD_W'(RAMP_FRAMES)) ? hold_q : hold_q + HOLD_W'(1);
                else
                    hold_d = '0;
                state_d = MOVE;
            end
            MOVE: begin
                if (btn_lat_q[1] && !btn_lat_q[0]) x_next = x_next - step_s;
                else if (btn_lat_q[0] && !btn_lat_q[1]) x_next = x_next + step_s;
                if (btn_lat_q[3] && !btn_lat_q[2]) y_next = y_next - step_s;
                else if (btn_lat_q[2] && !btn_lat_q[3]) y_next = y_next + step_s;

                if (x_next < 11'sd0) x_next = 11'sd0;
                else if (x_next > X_MAX) x_next = X_MAX;
                if (y_next < 11'sd0) y_next = 11'sd0;
                else if (y_next > Y_MAX) y_next = Y_MAX;

                pos_x_d = x_next[9:0];
                pos_y_d = y_next[9:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_lat_q    <= '0;
            step_q       <= 10'(STEP);
            hold_q       <= '0;
            vs_dly_q     <= 1'b1;
            frame_tick_q <= 1'b0;
            pix_col_q    <= '0;
            pix_row_q    <= '0;
            hit_q        <= 1'b0;
            pos_x_q      <= 10'(INIT_X);
            pos_y_q      <= 10'(INIT_Y);
        end else begin
            state_q      <= state_d;
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            btn_lat_q    <= btn_lat_d;
            step_q       <= step_d;
            hold_q       <= hold_d;
            vs_dly_q     <= vs_dly_d;
            frame_tick_q <= frame_tick_d;
            pix_col_q    <= pix_col_d;
            pix_row_q    <= pix_row_d;
            hit_q        <= hit_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign pix_col    = pix_col_q;
    assign pix_row    = pix_row_q;
    assign sprite_hit = hit_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/sprite_motion_controller.md
Name: sprite_motion_controller

Overview:
- Sequences the on-screen square sprite for the VGA pipeline.
- Samples the four direction buttons once per frame and moves the sprite by a step that ramps up while a button is held.
- Clamps the sprite to the active area and updates position only during vertical blanking.
- Keeps its own active-pixel column/row counters and drives a registered sprite_hit flag; the colour mux uses sprite_hit to override palette data.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- SIZE, 10, sprite edge length in pixels
- STEP, 1, pixels per frame while slow
- STEP_FAST, 4, pixels per frame after ramp
- RAMP_FRAMES, 30, consecutive held frames before fast step
- INIT_X, 315, reset column of sprite top-left
- INIT_Y, 235, reset row of sprite top-left

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- vs  in  1  vertical sync from video_sync_generator, active low
- blank_n  in  1  high during active video
- up  in  1  raw button, asynchronous to vga_clk
- down  in  1  raw button, asynchronous to vga_clk
- left  in  1  raw button, asynchronous to vga_clk
- right  in  1  raw button, asynchronous to vga_clk
- pos_x  out  10  sprite left column
- pos_y  out  10  sprite top row
- pix_col  out  10  current active column
- pix_row  out  10  current active row
- sprite_hit  out  1  registered: previous cycle's pixel lies inside the sprite
- frame_tick  out  1  one-cycle pulse at frame start

Behaviour:
- Reset (async, active-high, effective immediately including mid-FSM):
  - pos_x=INIT_X, pos_y=INIT_Y
  - pix_col=0, pix_row=0, sprite_hit=0, frame_tick=0
  - FSM=IDLE, hold_cnt=0, synchronizers=0, vs_d=1
- Button inputs: 2-flop synchronizers each. FSM sees only synchronized values.
- frame_tick:
  - Registered pulse, high for the cycle after vs_d=1 and vs=0 are both observed (falling edge of vs).
  - vs held low produces exactly one pulse.
- Pixel counters:
  - frame_tick cycle: col=0, row=0.
  - Otherwise, when blank_n=1: col+1; at col=H_ACTIVE-1, col wraps to 0 and row+1.
  - row wraps V_ACTIVE-1 -> 0.
  - blank_n=0: hold.
- sprite_hit:
  - Registered. Value in cycle n+1 = blank_n & (pos_x <= col < pos_x+SIZE) & (pos_y <= row < pos_y+SIZE), evaluated at cycle n.
  - Comparisons use 11-bit unsigned arithmetic, so there is no wrap at the right or bottom edge.
- FSM states IDLE -> CAPTURE -> MOVE -> IDLE:
  - IDLE: wait for frame_tick. Go to CAPTURE the next cycle.
  - CAPTURE:
    - Latch synchronized buttons.
    - step = (hold_cnt < RAMP_FRAMES) ? STEP : STEP_FAST.
    - Then update hold_cnt: if any button is pressed, hold_cnt+1 (saturating at RAMP_FRAMES); else hold_cnt=0.
  - MOVE: apply the latched buttons to pos_x/pos_y in one cycle, then return to IDLE.
  - Position changes only in MOVE, 2 cycles after frame_tick, inside vertical blanking.
  - A frame_tick arriving in CAPTURE or MOVE is ignored.
- Direction semantics:
  - left: x-step; right: x+step; up: y-step; down: y+step.
  - left&right together: x unchanged. up&down together: y unchanged.
  - x and y update independently in the same MOVE cycle.
- Clamping (11-bit signed intermediate):
  - x result clamped to [0, H_ACTIVE-SIZE].
  - y result clamped to [0, V_ACTIVE-SIZE].
  - A clamped press still counts toward hold_cnt.
- Latency:
  - Button change to position change: 2 sync cycles plus the next frame_tick plus 2 cycles.
  - Pixel to sprite_hit: 1 cycle.

Test Plan:
- Assert reset mid-frame with right held, release after 5 cycles -> pos=(315,235), hit=0, tick=0. First vs fall -> tick high exactly 1 cycle. pos unchanged with no buttons.
- Hold right for 3 frames -> pos_x 316, 317, 318, each changing 2 cycles after tick. pos_y stays 235.
- Hold right 35 frames from reset -> after frame 30 pos_x=345. Frames 31-35 step 4 -> 365. Release 1 frame then press -> step back to 1 (366).
- Set pos_x=628 via held right at fast step -> next frame pos_x=630 and stays 630 while held. From pos_x=2, left at step 4 -> 0.
- up+down+right held for one frame (slow) -> pos_y unchanged, pos_x+1. Assert reset during the MOVE cycle -> pos=(315,235), FSM IDLE, hold_cnt=0.
- With pos=(0,0), scan row 0 -> sprite_hit=1 for the cycles after col 0..9, 0 after col 10. Row 10 -> never hit. blank_n=0 -> hit=0.
